// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux block.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Select width for n channels; never narrower than one bit.
  function automatic int sel_width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping,
// with ptr itself checked last.
module rr_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_IN-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 grant_valid
);

  logic [SEL_WIDTH-1:0] idx;

  // Scan from farthest to nearest so the nearest requester overrides.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = SEL_WIDTH'((int'(ptr) + k) % NUM_IN);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-input registered stream mux with fixed-select or round-robin arbitration
// feeding a single output register stage.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_IN     = 4,
  parameter int SEL_WIDTH  = sel_width_for(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [DATA_WIDTH-1:0] chan_data [NUM_IN];
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;

  logic [SEL_WIDTH-1:0]  rr_grant, grant;
  logic                  rr_grant_valid, fix_valid, grant_valid;
  logic                  ld;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign chan_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  always_comb begin
    fix_valid = 1'b0;
    if (int'(sel) < NUM_IN) begin
      fix_valid = in_valid[sel];
    end
  end

  assign grant       = (mode == MODE_RR) ? rr_grant : sel;
  assign grant_valid = (mode == MODE_RR) ? rr_grant_valid : fix_valid;

  // Gating with rst_n keeps any handshake from completing while held in reset.
  assign ld = (!out_valid_q || out_ready) && rst_n;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = ld && grant_valid && (grant == SEL_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (ld) begin
      if (grant_valid) begin
        out_data_d  = chan_data[grant];
        out_sel_d   = grant;
        out_valid_d = 1'b1;
        ptr_d       = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_WIDTH'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Table-driven bench for stream_mux with a scoreboard of accepted beats.
module tb_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [2:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  stream_mux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] in_valid;
    logic       out_ready;
    logic [3:0] exp_in_ready;
    logic       exp_valid;
    logic [1:0] exp_sel;
  } vec_t;

  typedef struct {
    logic [2:0] data;
    logic [1:0] sel;
  } beat_t;

  vec_t       vecs [21];
  beat_t      sb_q [$];
  logic [2:0] chdata [4];
  logic [2:0] exp_data;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic apply(input int n, input vec_t v);
    beat_t b;
    mode      = v.mode;
    sel       = v.sel;
    in_valid  = v.in_valid;
    out_ready = v.out_ready;
    #1;
    chk($sformatf("in_ready[%0d]", n), int'(in_ready), int'(v.exp_in_ready));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk($sformatf("sb_underflow[%0d]", n), 1, 0);
      end else begin
        b = sb_q.pop_front();
        chk($sformatf("sb_data[%0d]", n), int'(out_data), int'(b.data));
        chk($sformatf("sb_sel[%0d]", n), int'(out_sel), int'(b.sel));
      end
    end
    if (v.exp_in_ready != 4'b0000) begin
      b.data = chdata[v.exp_sel];
      b.sel  = v.exp_sel;
      sb_q.push_back(b);
      exp_data = chdata[v.exp_sel];
    end
    @(posedge clk);
    #1;
    chk($sformatf("out_valid[%0d]", n), int'(out_valid), int'(v.exp_valid));
    chk($sformatf("out_sel[%0d]", n), int'(out_sel), int'(v.exp_sel));
    chk($sformatf("out_data[%0d]", n), int'(out_data), int'(exp_data));
    $display("vec %0d: mode=%0d sel=%0d in_valid=%b out_ready=%0d -> in_ready=%b out_valid=%0d out_sel=%0d out_data=%b",
             n, v.mode, v.sel, v.in_valid, v.out_ready, in_ready, out_valid, out_sel, out_data);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                              input logic ordy, input logic [3:0] er,
                              input logic ev, input logic [1:0] es);
    vec_t v;
    v.mode = m; v.sel = s; v.in_valid = iv; v.out_ready = ordy;
    v.exp_in_ready = er; v.exp_valid = ev; v.exp_sel = es;
    return v;
  endfunction

  initial begin
    vec_t v;
    chdata[0] = 3'b110;
    chdata[1] = 3'b011;
    chdata[2] = 3'b101;
    chdata[3] = 3'b001;
    in_data   = {chdata[3], chdata[2], chdata[1], chdata[0]};
    exp_data  = 3'b000;

    // Fixed sel=2, then round-robin all valid starting after ptr=2.
    vecs[0]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[1]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[2]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[3]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3);
    vecs[4]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    vecs[5]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    vecs[6]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[7]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3);
    vecs[8]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    // Only channels 1 and 3 requesting.
    vecs[9]  = mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
    vecs[10] = mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3);
    vecs[11] = mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
    vecs[12] = mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3);
    // Backpressure for three cycles, then reload in the same cycle.
    vecs[13] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    vecs[14] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    vecs[15] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    vecs[16] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    // Fixed sel=1 with channel 1 idle: drain, stay empty, then accept.
    vecs[17] = mk(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd0);
    vecs[18] = mk(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd0);
    vecs[19] = mk(1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    vecs[20] = mk(1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);

    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_sel", int'(out_sel), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    $display("reset: out_valid=%0d out_data=%b out_sel=%0d in_ready=%b", out_valid, out_data, out_sel, in_ready);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply(i, vecs[i]);
    end

    // Load a beat and hold it, then reset asynchronously mid-cycle.
    apply(21, mk(1'b0, 2'd3, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3));
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_out_data", int'(out_data), 0);
    chk("midreset_out_sel", int'(out_sel), 0);
    chk("midreset_in_ready", int'(in_ready), 0);
    $display("mid reset: out_valid=%0d out_data=%b out_sel=%0d in_ready=%b", out_valid, out_data, out_sel, in_ready);
    sb_q.delete();
    exp_data = 3'b000;
    @(posedge clk);
    #1;
    chk("held_reset_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // First round-robin grant after reset goes to channel 0.
    apply(22, mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0));
    apply(23, mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1));
    apply(24, mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1));

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-input, registered stream multiplexor with valid/ready handshaking on every channel. It is the successor of the team's fixed 2-input combinational mux. Each cycle it selects one input channel, either by an explicit select (fixed mode) or by round-robin arbitration, and moves that beat into a single output register stage. It sits between producer units and a shared downstream consumer in the datapath.

## Interface
Parameters:
- DATA_WIDTH, default 3: beat width in bits.
- NUM_IN, default 4: number of input channels, at least 2.
- SEL_WIDTH, default 2: select/tag width, equal to $clog2(NUM_IN).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_data  input  NUM_IN*DATA_WIDTH  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_WIDTH  channel index used in fixed mode.
- out_data  output  DATA_WIDTH  registered beat.
- out_sel  output  SEL_WIDTH  source channel of the registered beat.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

## Operation
- The load enable is ld = !out_valid | out_ready. The output stage accepts a new beat whenever it is empty or is being drained in the same cycle.
- Grant is combinational from in_valid, mode, sel and ptr:
  - Fixed mode: grant = sel, valid only if sel < NUM_IN and in_valid[sel].
  - Round-robin mode: grant is the first i with in_valid[i], scanning ptr+1, ptr+2, … modulo NUM_IN. The scan wraps; ptr itself is checked last.
- in_ready[i] = ld & grant_valid & (grant == i). All other channels see 0.
- Transfer on channel i (in_valid[i] & in_ready[i]):
  - out_data <= in_data[i], out_sel <= i, out_valid <= 1.
  - ptr <= i. This update happens in both modes.
- When ld is high and grant_valid is low: out_valid <= 0, and out_data/out_sel hold their previous values.
- When ld is low: the output register and ptr hold, and no input is ready.
- mode and sel are sampled every cycle. A change takes effect on the next accept and never alters a beat already registered.
- Reset state: out_valid = 0, out_data = 0, out_sel = 0, ptr = NUM_IN-1, so the first round-robin grant goes to channel 0.

## Timing
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle with out_ready held high; no bubble on back-to-back transfers.
- in_ready depends combinationally on in_valid, mode, sel and out_ready.
- in_valid, out_valid and out_data never depend combinationally on any ready signal.
- Reset asserted mid-transfer: outputs go to reset values immediately. An in-flight beat is dropped; no handshake completes while rst_n is low.
- out_data and out_sel are stable while out_valid & !out_ready.

## Structure
- Shared package stream_mux_pkg holds:
  - the MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants;
  - a clog2-based helper for SEL_WIDTH.
- Sub-module rr_arbiter (NUM_IN parameter) takes the request vector and ptr and produces grant index plus grant_valid. It is purely combinational. Fixed-mode selection and the output register stay in the top level.

## Test plan
- Reset: pulse rst_n low while out_valid = 1 -> out_valid, out_data and out_sel are 0 immediately. After release, with all in_valid high in round-robin mode, the first out_sel = 0.
- Fixed mode, sel = 2, all in_valid high, in_data[2] = 3'b101, out_ready = 1 -> in_ready = 4'b0100 every cycle; next-cycle out_data = 3'b101, out_sel = 2.
- Round-robin, all four channels valid continuously, out_ready = 1 -> out_sel sequence 0,1,2,3,0,1 with out_valid high every cycle.
- Round-robin, only channels 1 and 3 valid -> out_sel alternates 1,3,1,3. Channels 0 and 2 never see in_ready.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles -> in_ready = 0 and out_data stable. Then out_ready = 1 -> reload in the same cycle, with the next out_sel per round-robin order.
- Fixed mode, sel = 1, in_valid = 4'b1101 -> no in_ready asserted. An existing beat drains, then out_valid = 0 until in_valid[1] rises.
